// File: rtl/dvi_rx_pkg.sv
// Shared TMDS receive definitions: control tokens, token-to-code mapping and
// the word-aligner state encoding. Also imported by the TMDS decoder.
package dvi_rx_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } token_match_t;

    // code is {C1,C0}; it is only meaningful when hit is set
    function automatic token_match_t match_ctrl_token(input logic [9:0] word);
        token_match_t m;
        m.hit  = 1'b1;
        m.code = 2'b00;
        case (word)
            CTRL_TOKEN_00: m.code = 2'b00;
            CTRL_TOKEN_01: m.code = 2'b01;
            CTRL_TOKEN_10: m.code = 2'b10;
            CTRL_TOKEN_11: m.code = 2'b11;
            default:       m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dvi_rx_word_align_if.sv
// Word-aligner channel bundle: deserializer word in, bitslip and lock status out.
interface dvi_rx_word_align_if;
    logic [9:0] tmds_word;
    logic       bitslip;
    logic       aligned;
    logic       ctrl_token_det;
    logic [1:0] ctrl_code;
    logic [3:0] slip_count;

    // master: deserializer / channel side; slave: the aligner
    modport master (
        output tmds_word,
        input  bitslip,
        input  aligned,
        input  ctrl_token_det,
        input  ctrl_code,
        input  slip_count
    );

    modport slave (
        input  tmds_word,
        output bitslip,
        output aligned,
        output ctrl_token_det,
        output ctrl_code,
        output slip_count
    );
endinterface

// File: rtl/dvi_rx_ctrl_detect.sv
// Registered TMDS control-token matcher. The code register holds the last
// detected token so downstream logic sees a stable {C1,C0} between tokens.
module dvi_rx_ctrl_detect
    import dvi_rx_pkg::*;
(
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic [9:0] tmds_word_i,
    output logic       det_o,
    output logic [1:0] code_o
);

    token_match_t match_d;
    logic         det_q;
    logic [1:0]   code_q;

    assign match_d = match_ctrl_token(tmds_word_i);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            det_q  <= 1'b0;
            code_q <= 2'b00;
        end else begin
            det_q <= match_d.hit;
            if (match_d.hit) begin
                code_q <= match_d.code;
            end
        end
    end

    assign det_o  = det_q;
    assign code_o = code_q;

endmodule

// File: rtl/dvi_rx_word_align.sv
// Per-channel TMDS word aligner: slips the deserializer one bit at a time
// until a run of control tokens is seen, then reports the channel aligned.
//
// state  | meaning
// SEARCH | counting token runs / misses at the current slip position
// SLIP   | one-cycle bitslip pulse to the deserializer
// WAIT   | deserializer settling after a slip, detector ignored
// LOCKED | aligned; drops back to SEARCH after MISS_LIMIT missing tokens
module dvi_rx_word_align
    import dvi_rx_pkg::*;
#(
    parameter int CTRL_RUN   = 16,
    parameter int MISS_LIMIT = 4096,
    parameter int SLIP_WAIT  = 4
) (
    input  logic         pixel_clock,
    input  logic         reset,
    dvi_rx_word_align_if.slave bus
);

    localparam int                MISS_W    = (MISS_LIMIT > 2) ? $clog2(MISS_LIMIT) : 1;
    localparam logic [7:0]        RUN_LAST  = 8'(CTRL_RUN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    localparam logic [3:0]        WAIT_LOAD = 4'(SLIP_WAIT - 1);

    logic              det;
    logic [1:0]        code;

    align_state_e      state_q;
    logic [7:0]        run_cnt_q;
    logic [MISS_W-1:0] miss_cnt_q;
    logic [3:0]        wait_cnt_q;
    logic [3:0]        slip_count_q;
    logic [3:0]        slip_count_d;
    logic              bitslip_q;
    logic              aligned_q;
    logic              ctrl_token_det_q;
    logic [1:0]        ctrl_code_q;

    dvi_rx_ctrl_detect u_detect (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .tmds_word_i (bus.tmds_word),
        .det_o       (det),
        .code_o      (code)
    );

    assign slip_count_d = (slip_count_q == 4'd9) ? 4'd0 : slip_count_q + 4'd1;

    // Status outputs trail the detector by one more register stage.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            ctrl_token_det_q <= 1'b0;
            ctrl_code_q      <= 2'b00;
        end else begin
            ctrl_token_det_q <= det;
            ctrl_code_q      <= code;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_q      <= SEARCH;
            run_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            slip_count_q <= '0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (det) begin
                        miss_cnt_q <= '0;
                        if (run_cnt_q == RUN_LAST) begin
                            state_q   <= LOCKED;
                            aligned_q <= 1'b1;
                            run_cnt_q <= '0;
                        end else begin
                            run_cnt_q <= run_cnt_q + 8'd1;
                        end
                    end else begin
                        run_cnt_q <= '0;
                        if (miss_cnt_q == MISS_LAST) begin
                            state_q    <= SLIP;
                            bitslip_q  <= 1'b1;
                            miss_cnt_q <= '0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                        end
                    end
                end

                SLIP: begin
                    state_q      <= WAIT;
                    slip_count_q <= slip_count_d;
                    wait_cnt_q   <= WAIT_LOAD;
                    run_cnt_q    <= '0;
                    miss_cnt_q   <= '0;
                end

                // Words still shifting through the deserializer are untrusted.
                WAIT: begin
                    run_cnt_q  <= '0;
                    miss_cnt_q <= '0;
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= SEARCH;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end

                // Loss of lock re-searches from the current slip position.
                LOCKED: begin
                    run_cnt_q <= '0;
                    if (det) begin
                        miss_cnt_q <= '0;
                    end else if (miss_cnt_q == MISS_LAST) begin
                        state_q    <= SEARCH;
                        aligned_q  <= 1'b0;
                        miss_cnt_q <= '0;
                    end else begin
                        miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                    end
                end

                default: begin
                    state_q    <= SEARCH;
                    aligned_q  <= 1'b0;
                    run_cnt_q  <= '0;
                    miss_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.bitslip        = bitslip_q;
    assign bus.aligned        = aligned_q;
    assign bus.ctrl_token_det = ctrl_token_det_q;
    assign bus.ctrl_code      = ctrl_code_q;
    assign bus.slip_count     = slip_count_q;

endmodule

// File: tb/tb_dvi_rx_word_align.sv
// Directed bench for dvi_rx_word_align with CTRL_RUN=16, MISS_LIMIT=64, SLIP_WAIT=4.
module tb_dvi_rx_word_align;

    localparam int CTRL_RUN   = 16;
    localparam int MISS_LIMIT = 64;
    localparam int SLIP_WAIT  = 4;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] NOTOK = 10'h3ff;

    logic pixel_clock = 1'b0;
    logic reset       = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;
    logic slip_seen;
    int   rot;
    int   pulses[$];

    dvi_rx_word_align_if bus_if ();

    dvi_rx_word_align #(
        .CTRL_RUN   (CTRL_RUN),
        .MISS_LIMIT (MISS_LIMIT),
        .SLIP_WAIT  (SLIP_WAIT)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .bus         (bus_if)
    );

    always #5 pixel_clock = ~pixel_clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word is sampled at the next rising edge; outputs are looked at 1ns after it.
    task automatic cyc(input logic [9:0] w);
        bus_if.tmds_word = w;
        @(posedge pixel_clock);
        #1;
        edge_n++;
        if (bus_if.bitslip) slip_seen = 1'b1;
    endtask

    task automatic release_reset();
        bus_if.tmds_word = 10'h000;
        repeat (2) @(posedge pixel_clock);
        #1;
        reset     = 1'b0;
        edge_n    = 0;
        slip_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        release_reset();
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
        logic [9:0] t;
        t = w;
        for (int i = 0; i < r; i++) t = {t[8:0], t[9]};
        return t;
    endfunction

    function automatic logic [9:0] rnd_nontoken();
        logic [9:0] w;
        w = 10'($urandom);
        if (w == TOK00 || w == TOK01 || w == TOK10 || w == TOK11) w = w ^ 10'h001;
        return w;
    endfunction

    initial begin
        bus_if.tmds_word = 10'h000;
        slip_seen = 1'b0;

        // reset values
        do_reset();
        check("rst_bitslip", bus_if.bitslip, 0);
        check("rst_aligned", bus_if.aligned, 0);
        check("rst_det", bus_if.ctrl_token_det, 0);
        check("rst_code", bus_if.ctrl_code, 0);
        check("rst_slip_count", bus_if.slip_count, 0);

        // basic lock: tokens from edge 5, aligned after edge 21
        repeat (4) cyc(10'h000);
        cyc(TOK00);
        check("det_lat_edge5", bus_if.ctrl_token_det, 0);
        cyc(TOK00);
        check("det_lat_edge6", bus_if.ctrl_token_det, 1);
        while (edge_n < 20) cyc(TOK00);
        check("lock_edge20", bus_if.aligned, 0);
        cyc(TOK00);
        check("lock_edge21", bus_if.aligned, 1);
        check("lock_code", bus_if.ctrl_code, 2'b00);
        check("lock_no_slip", slip_seen, 0);

        // code mapping and hold: TOK10 @22, TOK11 @23, TOK01 @24
        cyc(TOK10);
        cyc(TOK11);
        check("code_10", bus_if.ctrl_code, 2'b10);
        cyc(TOK01);
        check("code_11", bus_if.ctrl_code, 2'b11);
        cyc(NOTOK);
        check("code_01", bus_if.ctrl_code, 2'b01);
        cyc(NOTOK);
        check("code_hold", bus_if.ctrl_code, 2'b01);
        check("code_hold_det", bus_if.ctrl_token_det, 0);

        // unlock: last token @24, aligned falls after edge 89
        while (edge_n < 88) cyc(NOTOK);
        check("unlock_edge88", bus_if.aligned, 1);
        cyc(NOTOK);
        check("unlock_edge89", bus_if.aligned, 0);
        check("unlock_no_slip", slip_seen, 0);
        check("unlock_slip_count", bus_if.slip_count, 0);

        // token at miss word 63 keeps lock
        do_reset();
        while (edge_n < 17) cyc(TOK00);
        check("relock_edge17", bus_if.aligned, 1);
        while (edge_n < 79) cyc(NOTOK);
        cyc(TOK11);
        while (edge_n < 82) cyc(NOTOK);
        check("keep_lock_edge82", bus_if.aligned, 1);
        while (edge_n < 144) cyc(NOTOK);
        check("keep_lock_edge144", bus_if.aligned, 1);
        cyc(NOTOK);
        check("late_unlock_edge145", bus_if.aligned, 0);

        // broken run: 15 tokens, one non-token, then 16 tokens from edge 17
        do_reset();
        while (edge_n < 15) cyc(TOK01);
        cyc(10'h155);
        check("broken_edge16", bus_if.aligned, 0);
        cyc(TOK01);
        check("broken_edge17", bus_if.aligned, 0);
        while (edge_n < 32) cyc(TOK01);
        check("rerun_edge32", bus_if.aligned, 0);
        cyc(TOK01);
        check("rerun_edge33", bus_if.aligned, 1);

        // rotated stream: slips at 64, 133, 202, lock at 223
        do_reset();
        rot = 3;
        pulses.delete();
        for (int i = 0; i < 400 && !bus_if.aligned; i++) begin
            cyc(rotl(TOK00, rot));
            if (bus_if.bitslip) begin
                pulses.push_back(edge_n);
                rot = (rot == 0) ? 9 : rot - 1;
            end
        end
        check("rot_pulses", pulses.size(), 3);
        check("rot_pulse0", pulses[0], 64);
        check("rot_pulse1", pulses[1], 133);
        check("rot_pulse2", pulses[2], 202);
        check("rot_slip_count", bus_if.slip_count, 3);
        check("rot_aligned", bus_if.aligned, 1);
        check("rot_lock_edge", edge_n, 223);

        // ten fruitless slips: slip_count 1..9 then 0
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            int n;
            n = 0;
            do begin
                cyc(rnd_nontoken());
                n++;
            end while (!bus_if.bitslip && n < 100);
            check("wrap_pulse_seen", bus_if.bitslip, 1);
            cyc(rnd_nontoken());
            check("wrap_slip_count", bus_if.slip_count, 32'(k % 10));
        end
        check("wrap_aligned", bus_if.aligned, 0);

        // reset asserted during the second SLIP cycle
        do_reset();
        for (int n = 0; n < 200 && edge_n < 133; n++) cyc(rnd_nontoken());
        check("rst_mid_pulse_pre", bus_if.bitslip, 1);
        check("rst_mid_count_pre", bus_if.slip_count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_bitslip", bus_if.bitslip, 0);
        check("rst_mid_slip_count", bus_if.slip_count, 0);
        check("rst_mid_aligned", bus_if.aligned, 0);
        check("rst_mid_det", bus_if.ctrl_token_det, 0);
        release_reset();
        while (edge_n < 16) cyc(TOK10);
        check("post_rst_edge16", bus_if.aligned, 0);
        cyc(TOK10);
        check("post_rst_edge17", bus_if.aligned, 1);
        check("post_rst_code", bus_if.ctrl_code, 2'b10);
        check("post_rst_no_slip", slip_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
